gbt_tx_frameclk_pll_supervisor: RTL and testbench
=================================================

GBT_TX_FRAMECLK_PLL_SUPERVISOR -- requirements
Module: gbt_tx_frameclk_pll_supervisor

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: PLL_RST_CYCLES, 16, cycles pll_rst_o is held high per PLL reset.
REQ-003 Parameter: LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before ready.
REQ-004 Parameter: LOCK_TIMEOUT_CYCLES, 1200000, maximum WAIT_LOCK duration (10 ms at 120 MHz).
REQ-005 Port: refclk  in  1  free-running 120 MHz reference clock, the same clock that feeds the frame-clock PLL.
REQ-006 Port: rst_n  in  1  synchronous active-low reset.
REQ-007 Port: pll_locked_i  in  1  asynchronous PLL locked flag.
REQ-008 Port: clear_i  in  1  single-cycle clear of loss_cnt_o and timeout_o.
REQ-009 Port: pll_rst_o  out  1  active-high PLL reset.
REQ-010 Port: frameclk_rst_o  out  1  active-high reset for frame-clock logic; equals NOT ready_o.
REQ-011 Port: ready_o  out  1  frame clock stable.
REQ-012 Port: timeout_o  out  1  sticky lock-timeout flag.
REQ-013 Port: loss_cnt_o  out  8  saturating count of lock losses seen in READY.
REQ-014 Port: state_o  out  3  current FSM state encoding, for debug.

Function
REQ-015 SHALL synchronise pll_locked_i through 2 flops; the FSM uses only the synced value (lock_s).
REQ-016 SHALL implement states RESET_PLL, WAIT_LOCK, STABILISE, READY and FAULT.
REQ-017 RESET_PLL: pll_rst_o=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-018 WAIT_LOCK: lock_s=1 -> STABILISE with stable counter=0; timer reaches LOCK_TIMEOUT_CYCLES-1 -> timeout_o=1, then -> RESET_PLL or FAULT per REQ-026.
REQ-019 STABILISE: the stable counter increments each cycle lock_s=1; lock_s=0 -> WAIT_LOCK with timer restarted; counter reaches LOCK_STABLE_CYCLES-1 -> READY.
REQ-020 ready_o SHALL rise exactly LOCK_STABLE_CYCLES+3 refclk edges after pll_locked_i rises, given lock held throughout.
REQ-021 READY: ready_o=1; lock_s=0 -> loss_cnt_o+1 (saturating at 255), ready_o=0 on the next edge, -> RESET_PLL.
REQ-022 clear_i and a loss event in the same cycle SHALL leave loss_cnt_o=1; clear_i clears timeout_o unless a timeout occurs in the same cycle, in which case timeout_o=1.
REQ-023 All counters SHALL be sized to their parameters with no wrap; the timer and stable counter are reset on every state entry.

Reset
REQ-024 rst_n=0 at an edge SHALL force state=RESET_PLL, pll_rst_o=1, frameclk_rst_o=1, ready_o=0, timeout_o=0, loss_cnt_o=0, all counters 0 and sync flops 0; this applies mid-operation from any state.
REQ-025 After rst_n release, the PLL_RST_CYCLES count SHALL begin on the first edge with rst_n=1.

Configuration
REQ-026 Macro GBT_PLL_SUP_AUTO_RETRY_EN: when defined, a WAIT_LOCK timeout -> RESET_PLL (unlimited retries); when undefined, a timeout -> FAULT, which holds pll_rst_o=1 and ready_o=0 until rst_n. FAULT is unreachable when the macro is defined.

Structure
REQ-027 Package gbt_pll_sup_pkg SHALL hold the state enum typedef (3 bits), the state_o encodings and the default parameter constants.
REQ-028 The 2-flop synchroniser SHALL be the sub-module gbt_bit_sync (1-bit, refclk domain).

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=50)
REQ-029 Release rst_n, then raise pll_locked_i 10 cycles later -> pll_rst_o high for 4 cycles, ready_o rises 11 edges after the lock rise, frameclk_rst_o falls on the same edge.
REQ-030 Lock glitch low for 1 cycle during STABILISE -> ready_o delayed; a full 8-cycle run is required after re-lock; loss_cnt_o stays 0.
REQ-031 Drop lock in READY 3 times -> loss_cnt_o=3, each drop followed by a 4-cycle pll_rst_o pulse; 260 drops -> loss_cnt_o=255.
REQ-032 Lock never asserted, macro defined -> timeout_o=1 after 50 WAIT_LOCK cycles and the PLL reset repeats; macro undefined -> state_o=FAULT, pll_rst_o held at 1.
REQ-033 clear_i coincident with a loss -> loss_cnt_o=1; rst_n pulsed low while in READY -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/gbt_pll_sup_pkg.sv
// Shared definitions for the GBT TX frame-clock PLL supervisor.
// Holds the FSM state enum (3 bits, also the state_o debug encoding),
// the default parameter constants and a counter-width helper.
package gbt_pll_sup_pkg;

  localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
  localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 1200000;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned LOSS_CNT_W = 8;

  // Values double as the state_o debug encoding.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILISE = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_e;

  // Bits needed for a counter that runs 0 .. max_cycles-1.
  function automatic int unsigned cnt_width(input int unsigned max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/gbt_bit_sync.sv
// Two-flop synchroniser for a single asynchronous bit into the clk domain.
// Ports:
//   clk    - destination clock
//   rst_n  - synchronous active-low reset, clears both flops
//   d_i    - asynchronous input bit
//   q_o    - synchronised output (two clk edges of latency)
module gbt_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gbt_tx_frameclk_pll_supervisor.sv
// Supervises the frame-clock PLL: pulses its reset, waits for lock, requires
// a run of stable lock before declaring the frame clock ready, counts lock
// losses while ready, and flags lock timeouts.
// Build option: define GBT_PLL_SUP_AUTO_RETRY_EN to retry the PLL reset after
// a lock timeout; without it a timeout parks the FSM in FAULT until rst_n.
// Ports:
//   refclk         - 120 MHz reference clock (also feeds the PLL)
//   rst_n          - synchronous active-low reset
//   pll_locked_i   - asynchronous PLL lock flag
//   clear_i        - single-cycle clear of loss_cnt_o and timeout_o
//   pll_rst_o      - active-high PLL reset
//   frameclk_rst_o - active-high frame-clock logic reset (NOT ready_o)
//   ready_o        - frame clock stable
//   timeout_o      - sticky lock-timeout flag
//   loss_cnt_o     - saturating count of lock losses seen while ready
//   state_o        - current FSM state (debug)
module gbt_tx_frameclk_pll_supervisor
  import gbt_pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked_i,
  input  logic                  clear_i,
  output logic                  pll_rst_o,
  output logic                  frameclk_rst_o,
  output logic                  ready_o,
  output logic                  timeout_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o,
  output logic [STATE_W-1:0]    state_o
);

  // One dwell counter serves the reset pulse, lock timer and stable run,
  // since only one of them is active in any state; it is sized to the
  // longest of the three so none can wrap.
  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);

  localparam logic [CNT_W-1:0]      RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = {LOSS_CNT_W{1'b1}};

  sup_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  ready_q, ready_d;
  logic                  frameclk_rst_q, frameclk_rst_d;
  logic                  timeout_q, timeout_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  lock_s;
  logic                  loss_evt;
  logic                  timeout_evt;

  gbt_bit_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  // State and output registers.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q        <= ST_RESET_PLL;
      cnt_q          <= '0;
      pll_rst_q      <= 1'b1;
      ready_q        <= 1'b0;
      frameclk_rst_q <= 1'b1;
      timeout_q      <= 1'b0;
      loss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_rst_q      <= pll_rst_d;
      ready_q        <= ready_d;
      frameclk_rst_q <= frameclk_rst_d;
      timeout_q      <= timeout_d;
      loss_cnt_q     <= loss_cnt_d;
    end
  end

  // Next-state, dwell counter and status logic. cnt_d defaults to zero so
  // every state change restarts the counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    timeout_d   = timeout_q;
    loss_cnt_d  = loss_cnt_q;
    loss_evt    = 1'b0;
    timeout_evt = 1'b0;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABILISE;
        end else if (cnt_q == TO_LAST) begin
          timeout_evt = 1'b1;
`ifdef GBT_PLL_SUP_AUTO_RETRY_EN
          state_d     = ST_RESET_PLL;
`else
          state_d     = ST_FAULT;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABILISE: begin
        if (!lock_s)                   state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_READY;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_READY: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
          state_d  = ST_RESET_PLL;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET_PLL;
    endcase

    // A loss coinciding with clear counts as the first loss after the clear.
    if (clear_i)                                  loss_cnt_d = loss_evt ? LOSS_CNT_W'(1) : '0;
    else if (loss_evt && (loss_cnt_q != LOSS_MAX)) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);

    // A same-cycle timeout wins over clear.
    if (timeout_evt)  timeout_d = 1'b1;
    else if (clear_i) timeout_d = 1'b0;

    pll_rst_d      = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    ready_d        = (state_d == ST_READY);
    frameclk_rst_d = !ready_d;
  end

  assign pll_rst_o      = pll_rst_q;
  assign frameclk_rst_o = frameclk_rst_q;
  assign ready_o        = ready_q;
  assign timeout_o      = timeout_q;
  assign loss_cnt_o     = loss_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_gbt_tx_frameclk_pll_supervisor.sv
// Scoreboard bench for gbt_tx_frameclk_pll_supervisor (PLL_RST=4, STABLE=8,
// TIMEOUT=50). Each driven cycle pushes the model's expected outputs; a
// monitor pops one entry per clock edge and compares.
module tb_gbt_tx_frameclk_pll_supervisor;
  import gbt_pll_sup_pkg::*;

  localparam int unsigned PRC = 4;
  localparam int unsigned STC = 8;
  localparam int unsigned TOC = 50;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       pll_rst_o;
  logic       frameclk_rst_o;
  logic       ready_o;
  logic       timeout_o;
  logic [7:0] loss_cnt_o;
  logic [2:0] state_o;

  typedef struct packed {
    logic       pll_rst;
    logic       frst;
    logic       ready;
    logic       timeout;
    logic [7:0] loss;
    logic [2:0] state;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: phase plus timestamp of the edge the phase was entered.
  logic       m_s1, m_s2;
  sup_state_e m_phase;
  int         now = 0;
  int         entered = 0;
  logic       m_to;
  int         m_loss;

  gbt_tx_frameclk_pll_supervisor #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_STABLE_CYCLES  (STC),
    .LOCK_TIMEOUT_CYCLES (TOC)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked_i),
    .clear_i        (clear_i),
    .pll_rst_o      (pll_rst_o),
    .frameclk_rst_o (frameclk_rst_o),
    .ready_o        (ready_o),
    .timeout_o      (timeout_o),
    .loss_cnt_o     (loss_cnt_o),
    .state_o        (state_o)
  );

  always #5 refclk = ~refclk;

  task automatic enter(input sup_state_e p);
    m_phase = p;
    entered = now;
  endtask

  // Advance the model by one refclk edge with the given inputs.
  task automatic model_edge(input logic r, input logic lk, input logic cl);
    logic ls;
    int   el;
    logic loss_ev;
    logic to_ev;
    now++;
    if (!r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_to = 1'b0; m_loss = 0;
      enter(ST_RESET_PLL);
    end else begin
      ls = m_s2; m_s2 = m_s1; m_s1 = lk;
      el = now - entered;
      loss_ev = 1'b0; to_ev = 1'b0;
      case (m_phase)
        ST_RESET_PLL: if (el == int'(PRC)) enter(ST_WAIT_LOCK);
        ST_WAIT_LOCK: begin
          if (ls) enter(ST_STABILISE);
          else if (el == int'(TOC)) begin
            to_ev = 1'b1;
`ifdef GBT_PLL_SUP_AUTO_RETRY_EN
            enter(ST_RESET_PLL);
`else
            enter(ST_FAULT);
`endif
          end
        end
        ST_STABILISE: begin
          if (!ls) enter(ST_WAIT_LOCK);
          else if (el == int'(STC)) enter(ST_READY);
        end
        ST_READY: if (!ls) begin loss_ev = 1'b1; enter(ST_RESET_PLL); end
        default: ;
      endcase
      if (cl) m_loss = loss_ev ? 1 : 0;
      else if (loss_ev && m_loss < 255) m_loss = m_loss + 1;
      if (to_ev) m_to = 1'b1;
      else if (cl) m_to = 1'b0;
    end
  endtask

  task automatic drive(input logic r, input logic lk, input logic cl);
    exp_t e;
    rst_n = r; pll_locked_i = lk; clear_i = cl;
    model_edge(r, lk, cl);
    e.pll_rst = (m_phase == ST_RESET_PLL) || (m_phase == ST_FAULT);
    e.ready   = (m_phase == ST_READY);
    e.frst    = !e.ready;
    e.timeout = m_to;
    e.loss    = 8'(m_loss);
    e.state   = m_phase;
    exp_q.push_back(e);
    @(negedge refclk);
  endtask

  task automatic hold(input int n, input logic lk);
    for (int i = 0; i < n; i++) drive(1'b1, lk, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Monitor: one scoreboard comparison per clock edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pll_rst_o, frameclk_rst_o, ready_o, timeout_o, loss_cnt_o, state_o};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got pll_rst=%b frst=%b ready=%b to=%b loss=%0d state=%0d required pll_rst=%b frst=%b ready=%b to=%b loss=%0d state=%0d",
                   $time, got.pll_rst, got.frst, got.ready, got.timeout, got.loss, got.state,
                   e.pll_rst, e.frst, e.ready, e.timeout, e.loss, e.state);
        end
      end
    end
  end

  initial begin
    // Power-up lock: 10 idle cycles, then hold lock until ready.
    do_reset(3);
    hold(10, 1'b0);
    hold(20, 1'b1);
    check("ready_after_lock", int'(ready_o), 1);
    check("frst_after_lock", int'(frameclk_rst_o), 0);

    // One-cycle glitch during STABILISE.
    do_reset(2);
    hold(6, 1'b0);
    hold(6, 1'b1);
    hold(1, 1'b0);
    hold(22, 1'b1);
    check("glitch_loss", int'(loss_cnt_o), 0);
    check("glitch_ready", int'(ready_o), 1);

    // Three losses in READY.
    for (int i = 0; i < 3; i++) begin
      hold(1, 1'b0);
      hold(20 + int'($urandom_range(0, 5)), 1'b1);
    end
    check("three_losses", int'(loss_cnt_o), 3);

    // Clear on the exact edge a loss is taken.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    hold(22, 1'b1);
    check("clear_with_loss", int'(loss_cnt_o), 1);

    // Saturation.
    for (int i = 0; i < 260; i++) begin
      hold(1, 1'b0);
      hold(18, 1'b1);
    end
    check("loss_saturated", int'(loss_cnt_o), 255);

    // Random lock runs with sporadic clears.
    for (int i = 0; i < 40; i++) begin
      logic lk;
      int   len;
      lk  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      for (int j = 0; j < len; j++) drive(1'b1, lk, 1'($urandom_range(0, 15) == 0));
    end

    // Lock never arrives.
    do_reset(2);
    hold(70, 1'b0);
    check("timeout_set", int'(timeout_o), 1);
`ifndef GBT_PLL_SUP_AUTO_RETRY_EN
    check("fault_state", int'(state_o), int'(ST_FAULT));
    check("fault_pll_rst", int'(pll_rst_o), 1);
`endif
    drive(1'b1, 1'b0, 1'b1);
    check("timeout_cleared", int'(timeout_o), 0);
    hold(10, 1'b1);

    // Reset pulse while READY.
    do_reset(2);
    hold(10, 1'b0);
    hold(20, 1'b1);
    check("ready_before_rst", int'(ready_o), 1);
    drive(1'b0, 1'b1, 1'b0);
    check("rst_ready", int'(ready_o), 0);
    check("rst_pll_rst", int'(pll_rst_o), 1);
    check("rst_state", int'(state_o), int'(ST_RESET_PLL));
    hold(5, 1'b1);

    @(posedge refclk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
